ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_if.sv | 43 ++++
 rtl/ram_port_arbiter.sv | 105 ++++++++++
 tb/tb_ram_port_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: sw, hw and RAM-side signal bundle for the RAM port arbiter
interface ram_port_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] sw_addr;
   logic              sw_ren;
   logic              sw_wen;
   logic [DATA_W-1:0] sw_wdata;
   logic [DATA_W-1:0] sw_rdata;
   logic              sw_access_complete;
   logic              sw_busy;
   logic [ADDR_W-1:0] hw_addr;
   logic              hw_ren;
   logic              hw_wen;
   logic [DATA_W-1:0] hw_wdata;
   logic [DATA_W-1:0] hw_rdata;
   logic              hw_access_complete;
   logic              hw_busy;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_ren;
   logic              ram_wen;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  sw_addr, sw_ren, sw_wen, sw_wdata,
      output sw_rdata, sw_access_complete, sw_busy,
      input  hw_addr, hw_ren, hw_wen, hw_wdata,
      output hw_rdata, hw_access_complete, hw_busy,
      output ram_addr, ram_ren, ram_wen, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output sw_addr, sw_ren, sw_wen, sw_wdata,
      input  sw_rdata, sw_access_complete, sw_busy,
      output hw_addr, hw_ren, hw_wen, hw_wdata,
      input  hw_rdata, hw_access_complete, hw_busy,
      input  ram_addr, ram_ren, ram_wen, ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one single-port RAM between sw and hw request ports
module ram_port_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
) (
   input logic               clk,
   input logic               res,
   ram_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
   state_t state, state_nx;
   logic gnt_hw, gnt_hw_nx, start, done, sel_op;
   logic sw_pend, hw_pend, sw_op, hw_op;
   logic [ADDR_W-1:0] sw_a, hw_a;
   logic [DATA_W-1:0] sw_d, hw_d;

   assign bus.sw_busy = sw_pend;
   assign bus.hw_busy = hw_pend;
   assign done = state == CAPTURE;
   assign sel_op = gnt_hw_nx ? hw_op : sw_op;

   // next state; in IDLE pick a pending port, alternating when both wait
   always_comb begin
      state_nx = state;
      gnt_hw_nx = gnt_hw;
      start = 1'b0;
      case (state)
         IDLE: if (sw_pend || hw_pend) begin
            start = 1'b1;
            gnt_hw_nx = hw_pend && (!sw_pend || !gnt_hw);
            state_nx = ISSUE;
         end
         ISSUE: state_nx = CAPTURE;
         default: state_nx = IDLE;
      endcase
   end

   // state and grant register; grant doubles as last-grant and resets to hw so sw wins the first tie
   always_ff @(posedge clk or posedge res)
      if (res) begin
         state <= IDLE;
         gnt_hw <= 1'b1;
      end else begin
         state <= state_nx;
         gnt_hw <= gnt_hw_nx;
      end

   // sw request slot: accept a strobe only when empty, release on its completion
   always_ff @(posedge clk or posedge res)
      if (res) begin
         sw_pend <= 1'b0;
         sw_a <= '0;
         sw_d <= '0;
         sw_op <= 1'b0;
      end else if (!sw_pend && (bus.sw_ren || bus.sw_wen)) begin
         sw_pend <= 1'b1;
         sw_a <= bus.sw_addr;
         sw_d <= bus.sw_wdata;
         sw_op <= bus.sw_wen;
      end else if (done && !gnt_hw) sw_pend <= 1'b0;

   // hw request slot: same behaviour as the sw slot
   always_ff @(posedge clk or posedge res)
      if (res) begin
         hw_pend <= 1'b0;
         hw_a <= '0;
         hw_d <= '0;
         hw_op <= 1'b0;
      end else if (!hw_pend && (bus.hw_ren || bus.hw_wen)) begin
         hw_pend <= 1'b1;
         hw_a <= bus.hw_addr;
         hw_d <= bus.hw_wdata;
         hw_op <= bus.hw_wen;
      end else if (done && gnt_hw) hw_pend <= 1'b0;

   // RAM command: strobes live only in ISSUE, address and data hold afterwards
   always_ff @(posedge clk or posedge res)
      if (res) begin
         bus.ram_ren <= 1'b0;
         bus.ram_wen <= 1'b0;
         bus.ram_addr <= '0;
         bus.ram_wdata <= '0;
      end else begin
         bus.ram_ren <= start && !sel_op;
         bus.ram_wen <= start && sel_op;
         if (start) begin
            bus.ram_addr <= gnt_hw_nx ? hw_a : sw_a;
            bus.ram_wdata <= gnt_hw_nx ? hw_d : sw_d;
         end
      end

   // completion pulse and read-data capture for the granted port only
   always_ff @(posedge clk or posedge res)
      if (res) begin
         bus.sw_access_complete <= 1'b0;
         bus.hw_access_complete <= 1'b0;
         bus.sw_rdata <= '0;
         bus.hw_rdata <= '0;
      end else begin
         bus.sw_access_complete <= done && !gnt_hw;
         bus.hw_access_complete <= done && gnt_hw;
         if (done && !gnt_hw && !sw_op) bus.sw_rdata <= bus.ram_rdata;
         if (done && gnt_hw && !hw_op) bus.hw_rdata <= bus.ram_rdata;
      end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed self-checking bench with a behavioural single-port RAM
module tb_ram_port_arbiter;
   logic clk = 1'b0;
   logic res = 1'b1;
   int checks = 0;
   int failures = 0;
   int wr_cnt = 0, rd_cnt = 0, sw_pulse = 0, hw_pulse = 0;
   logic [15:0] mem [32];
   logic [15:0] q;

   ram_port_arbiter_if #(.ADDR_W(5), .DATA_W(16)) bus ();

   ram_port_arbiter #(.ADDR_W(5), .DATA_W(16)) dut (.clk(clk), .res(res), .bus(bus));

   always #5 clk = ~clk;

   // RAM model: read data valid the cycle after ram_ren is sampled
   always @(posedge clk) begin
      if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_addr];
   end

   // event counters sampled away from the active edge
   always @(negedge clk) begin
      if (bus.ram_wen) wr_cnt++;
      if (bus.ram_ren) rd_cnt++;
      if (bus.sw_access_complete) sw_pulse++;
      if (bus.hw_access_complete) hw_pulse++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // one strobe from a single port, wait for its completion, return the port's rdata
   task automatic access(input bit hw, input bit r, input bit w, input logic [4:0] a,
                         input logic [15:0] d, output logic [15:0] rq);
      int n;
      if (hw) begin
         bus.hw_addr = a; bus.hw_wdata = d; bus.hw_ren = r; bus.hw_wen = w;
      end else begin
         bus.sw_addr = a; bus.sw_wdata = d; bus.sw_ren = r; bus.sw_wen = w;
      end
      @(negedge clk);
      bus.sw_ren = 1'b0; bus.sw_wen = 1'b0; bus.hw_ren = 1'b0; bus.hw_wen = 1'b0;
      chk(hw ? "hw_busy" : "sw_busy", 32'(hw ? bus.hw_busy : bus.sw_busy), 1);
      n = 0;
      while (!(hw ? bus.hw_access_complete : bus.sw_access_complete) && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("done_latency", n, 3);
      rq = hw ? bus.hw_rdata : bus.sw_rdata;
      @(negedge clk);
      chk("pulse_width", 32'(hw ? bus.hw_access_complete : bus.sw_access_complete), 0);
   endtask

   initial begin
      int w0, r0, p0, g, n;
      int ga [8];
      int gc [8];
      bus.sw_addr = '0; bus.sw_wdata = '0; bus.sw_ren = 1'b0; bus.sw_wen = 1'b0;
      bus.hw_addr = '0; bus.hw_wdata = '0; bus.hw_ren = 1'b0; bus.hw_wen = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_sw_busy", 32'(bus.sw_busy), 0);
      chk("rst_hw_busy", 32'(bus.hw_busy), 0);
      chk("rst_ram_ren", 32'(bus.ram_ren), 0);
      chk("rst_ram_wen", 32'(bus.ram_wen), 0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 0);
      chk("rst_sw_rdata", 32'(bus.sw_rdata), 0);
      chk("rst_sw_done", 32'(bus.sw_access_complete), 0);
      res = 1'b0;
      // single sw write, cycle by cycle
      bus.sw_addr = 5'd3; bus.sw_wdata = 16'h00A5; bus.sw_wen = 1'b1;
      @(negedge clk);
      bus.sw_wen = 1'b0;
      chk("w_busy0", 32'(bus.sw_busy), 1);
      chk("w_nocmd", 32'(bus.ram_wen), 0);
      @(negedge clk);
      chk("w_ram_wen", 32'(bus.ram_wen), 1);
      chk("w_ram_addr", 32'(bus.ram_addr), 3);
      chk("w_ram_wdata", 32'(bus.ram_wdata), 32'h00A5);
      chk("w_busy1", 32'(bus.sw_busy), 1);
      @(negedge clk);
      chk("w_wen_drop", 32'(bus.ram_wen), 0);
      chk("w_addr_hold", 32'(bus.ram_addr), 3);
      chk("w_busy2", 32'(bus.sw_busy), 1);
      chk("w_no_done", 32'(bus.sw_access_complete), 0);
      @(negedge clk);
      chk("w_done", 32'(bus.sw_access_complete), 1);
      chk("w_busy3", 32'(bus.sw_busy), 0);
      @(negedge clk);
      chk("w_done_end", 32'(bus.sw_access_complete), 0);
      chk("w_wr_count", wr_cnt, 1);
      // fill via sw, read back via hw
      for (int i = 0; i < 32; i++) access(1'b0, 1'b0, 1'b1, 5'(i), 16'(i + 32), q);
      for (int i = 0; i < 32; i++) begin
         access(1'b1, 1'b1, 1'b0, 5'(i), 16'h0, q);
         chk("hw_read", 32'(q), 32'(i + 32));
      end
      chk("sw_rdata_untouched", 32'(bus.sw_rdata), 0);
      // strobe while busy is ignored
      r0 = rd_cnt; p0 = sw_pulse;
      bus.sw_addr = 5'd3; bus.sw_ren = 1'b1;
      @(negedge clk);
      bus.sw_addr = 5'd7;
      @(negedge clk);
      bus.sw_ren = 1'b0;
      repeat (8) @(negedge clk);
      chk("dup_reads", rd_cnt - r0, 1);
      chk("dup_pulses", sw_pulse - p0, 1);
      chk("dup_rdata", 32'(bus.sw_rdata), 35);
      chk("hw_rdata_untouched", 32'(bus.hw_rdata), 63);
      // ren+wen together is a write
      w0 = wr_cnt; r0 = rd_cnt;
      access(1'b0, 1'b1, 1'b1, 5'd5, 16'h1234, q);
      chk("both_wr", wr_cnt - w0, 1);
      chk("both_rd", rd_cnt - r0, 0);
      access(1'b0, 1'b1, 1'b0, 5'd5, 16'h0, q);
      chk("both_readback", 32'(q), 32'h1234);
      // simultaneous streams after reset alternate strictly, sw first
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      bus.sw_addr = 5'd1; bus.sw_wdata = 16'h0001; bus.sw_wen = 1'b1;
      bus.hw_addr = 5'd2; bus.hw_wdata = 16'h0002; bus.hw_wen = 1'b1;
      g = 0; n = 0;
      while (g < 8 && n < 60) begin
         @(negedge clk);
         n++;
         if (bus.ram_wen) begin
            ga[g] = 32'(bus.ram_addr);
            gc[g] = n;
            g++;
         end
      end
      bus.sw_wen = 1'b0; bus.hw_wen = 1'b0;
      chk("rr_count", g, 8);
      chk("rr_first_lat", gc[0], 2);
      for (int i = 0; i < 8; i++) begin
         chk("rr_port", ga[i], (i % 2 == 0) ? 1 : 2);
         if (i > 0) chk("rr_gap", gc[i] - gc[i-1], 3);
      end
      repeat (12) @(negedge clk);
      // reset during ISSUE of an hw read aborts it
      bus.hw_addr = 5'd4; bus.hw_ren = 1'b1;
      @(negedge clk);
      bus.hw_ren = 1'b0;
      chk("ab_busy", 32'(bus.hw_busy), 1);
      @(negedge clk);
      chk("ab_issue", 32'(bus.ram_ren), 1);
      #1 res = 1'b1;
      #1;
      chk("ab_ram_ren", 32'(bus.ram_ren), 0);
      chk("ab_hw_busy", 32'(bus.hw_busy), 0);
      chk("ab_ram_addr", 32'(bus.ram_addr), 0);
      chk("ab_ram_wdata", 32'(bus.ram_wdata), 0);
      chk("ab_hw_rdata", 32'(bus.hw_rdata), 0);
      @(negedge clk);
      p0 = hw_pulse;
      res = 1'b0;
      access(1'b0, 1'b1, 1'b0, 5'd6, 16'h0, q);
      chk("ab_sw_read", 32'(q), 38);
      repeat (4) @(negedge clk);
      chk("ab_no_hw_done", hw_pulse - p0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
